// File: rtl/dmem_pkg.sv
// Shared constants and MMIO decode for the data-side memory responder.
// Imported by dmem_responder; holds no logic of its own besides decode.
package dmem_pkg;

  localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;

  localparam logic [7:0] OFF_CYCLE_LO = 8'h00;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h04;
  localparam logic [7:0] OFF_TX_DATA  = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h0C;

  localparam int ST_FULL  = 8;
  localparam int ST_EMPTY = 9;
  localparam int ST_OVF   = 10;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LO,
    SEL_HI,
    SEL_TX,
    SEL_ST
  } mmio_sel_e;

  function automatic mmio_sel_e mmio_decode(
    input logic [7:0] off
  );
    mmio_sel_e s;
    unique case (1'b1)
      (off == OFF_CYCLE_LO): s = SEL_LO;
      (off == OFF_CYCLE_HI): s = SEL_HI;
      (off == OFF_TX_DATA):  s = SEL_TX;
      (off == OFF_STATUS):   s = SEL_ST;
      default:               s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Circular transmit FIFO with occupancy count; no push-to-head bypass.
// Ports: CLK, RST, push/push_data, pop, head, count, full, empty.
module tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;
  logic             pop_ok;
  logic             push_ok;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = empty ? '0 : mem_q[rd_q];

  // A full FIFO still accepts a push when the head leaves
  // on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      unique case (1'b1)
        (push_ok && !pop_ok): cnt_q <= cnt_q + CW'(1);
        (pop_ok && !push_ok): cnt_q <= cnt_q - CW'(1);
        default:              cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: word RAM, 64-bit cycle counter, byte TX FIFO.
// Ports: core data port (DataMem*), console tx_valid/tx_data/tx_ready.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DataMemAddr,
  input  logic        DataMemRead,
  input  logic        DataMemWrite,
  input  logic [31:0] DataMemWData,
  output logic [31:0] DataMemRData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int IW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   mem [RAM_WORDS];
  logic [63:0]   cycle_q;
  logic [31:0]   hi_q;
  logic          ovf_q;
  logic          is_mmio;
  logic [IW-1:0] ram_idx;
  mmio_sel_e     sel;
  logic          rd_lo;
  logic          wr_lo;
  logic          wr_tx;
  logic          wr_st;
  logic          pop;
  logic          drop;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [31:0]   status;
  logic          unused_addr;

  // Bits [1:0] and the aliasing upper bits are don't-care.
  assign unused_addr = ^DataMemAddr;

  assign is_mmio = (DataMemAddr[31:16] == MMIO_BASE_HI);
  assign ram_idx = DataMemAddr[IW+1:2];
  assign sel     = is_mmio ? mmio_decode(DataMemAddr[7:0])
                           : SEL_NONE;

  assign rd_lo = DataMemRead  && (sel == SEL_LO);
  assign wr_lo = DataMemWrite && (sel == SEL_LO);
  assign wr_tx = DataMemWrite && (sel == SEL_TX);
  assign wr_st = DataMemWrite && (sel == SEL_ST);

  assign pop  = tx_valid && tx_ready;
  assign drop = wr_tx && full && !pop;

  tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (8)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (wr_tx),
    .push_data(DataMemWData[7:0]),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign tx_valid = !empty;
  assign tx_data  = head;

  always_ff @(posedge CLK) begin
    if (DataMemWrite && !is_mmio) begin
      mem[ram_idx] <= DataMemWData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_q <= '0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= wr_lo ? '0 : cycle_q + 64'd1;
      // Snapshot HI with the LO read so the pair is coherent.
      if (rd_lo) hi_q <= cycle_q[63:32];
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (wr_st && DataMemWData[ST_OVF]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_comb begin
    status           = '0;
    status[7:0]      = 8'(count);
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF]   = ovf_q;
  end

  always_comb begin
    DataMemRData = '0;
    if (DataMemRead) begin
      if (!is_mmio) begin
        DataMemRData = mem[ram_idx];
      end else begin
        unique case (sel)
          SEL_LO:  DataMemRData = cycle_q[31:0];
          SEL_HI:  DataMemRData = hi_q;
          SEL_ST:  DataMemRData = status;
          default: DataMemRData = '0;
        endcase
      end
    end
  end

endmodule
